// File: rtl/array_pkg.sv
// -----------------------------------------------------------------------------
// array_pkg
// Shared types for the 4x4 systolic array output path.
//   LANES / LANE_W : lane count and lane width of the array columns
//   lane_t         : one lane value
//   vec_t          : one packed result vector {y0,y1,y2,y3}, y0 in the MSBs
//   coll_state_t   : batch FSM states of the output collector
//   relu_vec()     : clamps every negative two's-complement lane of a vector to 0
// -----------------------------------------------------------------------------
package array_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;

    typedef logic [LANE_W-1:0]       lane_t;
    typedef logic [LANES*LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } coll_state_t;

    // Lane k occupies bits [k*LANE_W +: LANE_W]; its MSB is the sign bit.
    function automatic vec_t relu_vec(input vec_t v);
        vec_t r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (v[k*LANE_W + LANE_W - 1]) begin
                r[k*LANE_W +: LANE_W] = '0;
            end else begin
                r[k*LANE_W +: LANE_W] = v[k*LANE_W +: LANE_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO holding realigned result vectors. The caller qualifies push
// and pop (push may be asserted while full only together with pop). Head entry
// is read straight from the storage registers.
// Ports:
//   clk, rst        posedge clock, asynchronous active-high reset
//   push, wr_data   write one entry
//   pop             remove the head entry
//   rd_data         head entry
//   full, empty     occupancy flags decoded from the registered count
// -----------------------------------------------------------------------------
module result_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == CW'(0));

endmodule

// File: rtl/array_out_collector.sv
// -----------------------------------------------------------------------------
// array_out_collector
// Realigns the skewed column outputs of the 4x4 systolic array into one vector
// per input vector, buffers them in a FIFO and hands them out on valid/ready.
// A batch FSM counts NUM_VEC vectors, waits for the FIFO to drain, then pulses
// batch_done.
// Optional build macro: COLLECTOR_RELU_EN -- negative lanes are clamped to 0 at
// the FIFO write port (no extra latency). Without it lanes are stored bit-exact.
// Ports:
//   clk, rst     posedge clock, asynchronous active-high reset
//   arr_out      skewed array output {y0,y1,y2,y3}, lane k lags lane 0 by k cycles
//   arr_out_en   lane 0 of arr_out is valid this cycle
//   m_data       head vector {r0,r1,r2,r3}
//   m_valid      m_data holds a vector
//   m_ready      consumer takes the vector when m_valid && m_ready
//   batch_done   one-cycle pulse when the batch has drained
//   overflow     sticky: a vector was dropped because the FIFO was full
//   vec_count    vectors counted into the current batch
// -----------------------------------------------------------------------------
module array_out_collector
    import array_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_VEC    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*LANE_W-1:0]   arr_out,
    input  logic                      arr_out_en,
    output logic [LANES*LANE_W-1:0]   m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      batch_done,
    output logic                      overflow,
    output logic [7:0]                vec_count
);

    localparam logic [7:0] NUM_VEC_C = 8'(NUM_VEC);

    lane_t       y0_d1_r, y0_d2_r, y0_d3_r;
    lane_t       y1_d1_r, y1_d2_r;
    lane_t       y2_d1_r;
    logic [2:0]  en_pipe_r;

    vec_t        wr_raw_s;
    vec_t        wr_word_s;
    vec_t        head_s;
    logic        wr_en_s;
    logic        push_s;
    logic        pop_s;
    logic        count_push_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;

    coll_state_t state_r;
    coll_state_t next_state_s;
    logic [7:0]  vec_count_r;
    logic        overflow_r;

    // Deskew pipes: lane k is held 3-k cycles so all four lanes line up with lane 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0_d1_r   <= '0;
            y0_d2_r   <= '0;
            y0_d3_r   <= '0;
            y1_d1_r   <= '0;
            y1_d2_r   <= '0;
            y2_d1_r   <= '0;
            en_pipe_r <= 3'b000;
        end else begin
            y0_d1_r   <= arr_out[4*LANE_W-1 -: LANE_W];
            y0_d2_r   <= y0_d1_r;
            y0_d3_r   <= y0_d2_r;
            y1_d1_r   <= arr_out[3*LANE_W-1 -: LANE_W];
            y1_d2_r   <= y1_d1_r;
            y2_d1_r   <= arr_out[2*LANE_W-1 -: LANE_W];
            en_pipe_r <= {en_pipe_r[1:0], arr_out_en};
        end
    end

    assign wr_en_s  = en_pipe_r[2];
    assign wr_raw_s = {y0_d3_r, y1_d2_r, y2_d1_r, arr_out[LANE_W-1:0]};

`ifdef COLLECTOR_RELU_EN
    assign wr_word_s = relu_vec(wr_raw_s);
`else
    assign wr_word_s = wr_raw_s;
`endif

    // Handshake qualification; a full FIFO still accepts a word when it pops in the same cycle.
    always_comb begin
        pop_s        = !fifo_empty_s && m_ready;
        push_s       = wr_en_s && (!fifo_full_s || pop_s);
        count_push_s = push_s
                    && ((state_r == IDLE) || (state_r == COLLECT))
                    && (vec_count_r < NUM_VEC_C);
    end

    result_fifo #(
        .DATA_W (LANES*LANE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (wr_word_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (wr_en_s && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Batch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Batch FSM next state. The count stops at NUM_VEC, so a word arriving in the
    // cycle where COLLECT sees the full count is written but not counted.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_push_s) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COLLECT: begin
                if (vec_count_r == NUM_VEC_C) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            DRAIN: begin
                if (fifo_empty_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Batch vector counter; cleared as DONE hands back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count_r <= 8'd0;
        end else if (state_r == DONE) begin
            vec_count_r <= 8'd0;
        end else if (count_push_s) begin
            vec_count_r <= vec_count_r + 8'd1;
        end else begin
            vec_count_r <= vec_count_r;
        end
    end

    assign m_data     = head_s;
    assign m_valid    = !fifo_empty_s;
    assign batch_done = (state_r == DONE);
    assign overflow   = overflow_r;
    assign vec_count  = vec_count_r;

endmodule

// File: tb/tb_array_out_collector.sv
// -----------------------------------------------------------------------------
// tb_array_out_collector
// Drives skewed array vectors cycle by cycle and compares every output after
// each clock edge against a queue-based reference of the collector behaviour.
// Define COLLECTOR_RELU_EN for both bench and RTL to exercise the clamp build.
// -----------------------------------------------------------------------------
module tb_array_out_collector;

    localparam int NUM_VEC = 7;
    localparam int DEPTH   = 8;
    localparam int HIST    = 2048;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_DONE    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] arr_out;
    logic        arr_out_en;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        batch_done;
    logic        overflow;
    logic [7:0]  vec_count;

    always #5 clk = ~clk;

    array_out_collector #(
        .FIFO_DEPTH (DEPTH),
        .NUM_VEC    (NUM_VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arr_out    (arr_out),
        .arr_out_en (arr_out_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .batch_done (batch_done),
        .overflow   (overflow),
        .vec_count  (vec_count)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state
    logic [63:0] exp_q[$];
    int          ph;
    int          cnt;
    bit          ovf;
    int          base;
    int          cyc;
    int          done_pulses;
    bit          en_hist  [HIST];
    logic [63:0] vec_hist [HIST];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] relu_exp(input logic [63:0] v);
        logic [63:0] r;
        r = v;
`ifdef COLLECTOR_RELU_EN
        for (int k = 0; k < 4; k++) begin
            if (v[16*k + 15]) r[16*k +: 16] = 16'h0000;
        end
`endif
        return r;
    endfunction

    // Reference update for the clock edge that ends cycle c.
    task automatic model_edge(input int c, input bit rdy);
        bit          pop_m, wr_m, full_m, acc_m, cnt_m;
        logic [63:0] w;
        int          ph_next;
        pop_m = (exp_q.size() > 0) && rdy;
        wr_m  = 1'b0;
        w     = '0;
        if (c - 3 >= base) begin
            wr_m = en_hist[c-3];
            w    = relu_exp(vec_hist[c-3]);
        end
        full_m = (exp_q.size() == DEPTH);
        acc_m  = wr_m && (!full_m || pop_m);
        cnt_m  = acc_m && (ph == P_IDLE || ph == P_COLLECT) && (cnt < NUM_VEC);
        ph_next = ph;
        case (ph)
            P_IDLE:    if (cnt_m) ph_next = P_COLLECT;
            P_COLLECT: if (cnt == NUM_VEC) ph_next = P_DRAIN;
            P_DRAIN:   if (exp_q.size() == 0) ph_next = P_DONE;
            default:   ph_next = P_IDLE;
        endcase
        if (ph == P_DONE) cnt = 0;
        else if (cnt_m) cnt++;
        if (wr_m && full_m && !pop_m) ovf = 1'b1;
        if (pop_m) void'(exp_q.pop_front());
        if (acc_m) exp_q.push_back(w);
        ph = ph_next;
    endtask

    // One clock cycle: present lane k of the vector launched k cycles ago, clock, compare.
    task automatic step(input bit en, input logic [63:0] vec, input bit rdy);
        logic [63:0] a;
        int          src;
        en_hist[cyc]  = en;
        vec_hist[cyc] = vec;
        a = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            src = cyc - k;
            if (src >= 0) begin
                if (en_hist[src]) a[63-16*k -: 16] = vec_hist[src][63-16*k -: 16];
            end
        end
        arr_out    = a;
        arr_out_en = en;
        m_ready    = rdy;
        @(posedge clk);
        model_edge(cyc, rdy);
        #1;
        check_eq("m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) check_eq("m_data", m_data, exp_q[0]);
        check_eq("batch_done", {63'd0, batch_done}, {63'd0, ph == P_DONE});
        check_eq("overflow", {63'd0, overflow}, {63'd0, ovf});
        check_eq("vec_count", {56'd0, vec_count}, 64'(cnt));
        if (batch_done) done_pulses++;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, rdy);
    endtask

    task automatic rand_vecs(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, {$urandom, $urandom}, rdy);
    endtask

    // Asynchronous reset between edges; outputs must drop before any clock.
    task automatic do_reset(input string tag);
        #1;
        rst = 1'b1;
        #1;
        check_eq({tag, "_m_valid"},    {63'd0, m_valid},    64'd0);
        check_eq({tag, "_m_data"},     m_data,              64'd0);
        check_eq({tag, "_vec_count"},  {56'd0, vec_count},  64'd0);
        check_eq({tag, "_overflow"},   {63'd0, overflow},   64'd0);
        check_eq({tag, "_batch_done"}, {63'd0, batch_done}, 64'd0);
        arr_out_en = 1'b0;
        m_ready    = 1'b0;
        arr_out    = 64'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ph   = P_IDLE;
        cnt  = 0;
        ovf  = 1'b0;
        base = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        int          max_cnt;
        logic [63:0] relu_in;
        logic [63:0] relu_want;

        rst = 1'b1; arr_out = 64'd0; arr_out_en = 1'b0; m_ready = 1'b0;
        cyc = 0; base = 0; ph = P_IDLE; cnt = 0; ovf = 1'b0; done_pulses = 0;
        do_reset("rst0");

        // Single vector, 3-cycle latency, then popped.
        step(1'b1, 64'h0011_0022_0033_0044, 1'b1);
        idle(3, 1'b1);
        check_eq("t1_valid", {63'd0, m_valid}, 64'd1);
        check_eq("t1_data", m_data, 64'h0011_0022_0033_0044);
        idle(1, 1'b1);
        check_eq("t1_popped", {63'd0, m_valid}, 64'd0);
        do_reset("t1_rst");

        // Full batch with a ready consumer.
        d0 = done_pulses;
        max_cnt = 0;
        for (int i = 0; i < NUM_VEC; i++) begin
            step(1'b1, {$urandom, $urandom}, 1'b1);
            if (int'(vec_count) > max_cnt) max_cnt = int'(vec_count);
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 64'd0, 1'b1);
            if (int'(vec_count) > max_cnt) max_cnt = int'(vec_count);
        end
        check_eq("t2_max_count", 64'(max_cnt), 64'd7);
        check_eq("t2_done_pulses", 64'(done_pulses - d0), 64'd1);
        check_eq("t2_count_clear", {56'd0, vec_count}, 64'd0);

        // Overflow: nine vectors into an eight-deep FIFO with no consumer.
        rand_vecs(9, 1'b0);
        idle(3, 1'b0);
        check_eq("t3_overflow", {63'd0, overflow}, 64'd1);
        check_eq("t3_count_cap", {56'd0, vec_count}, 64'd7);
        check_eq("t3_valid", {63'd0, m_valid}, 64'd1);
        idle(14, 1'b1);
        do_reset("t3_rst");

        // Full FIFO accepting a write in the same cycle as a pop.
        rand_vecs(8, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        check_eq("t4_no_overflow", {63'd0, overflow}, 64'd0);
        check_eq("t4_valid", {63'd0, m_valid}, 64'd1);
        idle(14, 1'b1);

        // Reset with three words buffered and two still in the deskew pipe.
        rand_vecs(5, 1'b0);
        idle(1, 1'b0);
        do_reset("t5_rst");
        d0 = done_pulses;
        rand_vecs(NUM_VEC, 1'b1);
        idle(14, 1'b1);
        check_eq("t5_done_pulses", 64'(done_pulses - d0), 64'd1);

        // Sign handling of lanes at the write port.
        relu_in = 64'hFFFF_7FFF_8000_0001;
`ifdef COLLECTOR_RELU_EN
        relu_want = 64'h0000_7FFF_0000_0001;
`else
        relu_want = 64'hFFFF_7FFF_8000_0001;
`endif
        step(1'b1, relu_in, 1'b0);
        idle(3, 1'b0);
        check_eq("t6_data", m_data, relu_want);
        idle(4, 1'b1);
        do_reset("t6_rst");

        // Random traffic with a mostly-ready consumer.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end
        idle(20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
